// File: rtl/adder_word_loader_pkg.sv
// Shared types for the word-serial front/back end of the wide adder.
// Default widths and the loader state encoding.
package adder_word_loader_pkg;

    localparam int N_DEF = 128;
    localparam int W_DEF = 32;

    typedef enum logic [1:0] {
        LOAD_A,
        LOAD_B,
        ADD,
        OUT
    } state_e;

endpackage

// File: rtl/bit_adder_2n.sv
// N-bit parallel-prefix (Kogge-Stone) carry-lookahead adder.
// Also reports the whole-group propagate and generate terms.
module bit_adder_2n #(
    parameter int N = 128
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         cin_i,
    output logic [N-1:0] sum_o,
    output logic         cout_o,
    output logic         p_o,
    output logic         g_o
);

    localparam int L = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0] p0;
    logic [N-1:0] g0;
    logic [N-1:0] gp;
    logic [N-1:0] pp;
    logic [N:0]   c;

    assign p0 = a_i ^ b_i;
    assign g0 = a_i & b_i;

    for (genvar l = 0; l < L; l++) begin : g_lvl
        logic [N-1:0] gin;
        logic [N-1:0] pin;
        logic [N-1:0] go;
        logic [N-1:0] po;
        if (l == 0) begin : g_src
            assign gin = g0;
            assign pin = p0;
        end else begin : g_src
            assign gin = g_lvl[l-1].go;
            assign pin = g_lvl[l-1].po;
        end
        for (genvar i = 0; i < N; i++) begin : g_bit
            if (i >= (1 << l)) begin : g_mrg
                assign go[i] = gin[i] | (pin[i] & gin[i-(1<<l)]);
                assign po[i] = pin[i] & pin[i-(1<<l)];
            end else begin : g_cpy
                assign go[i] = gin[i];
                assign po[i] = pin[i];
            end
        end
    end

    assign gp = g_lvl[L-1].go;
    assign pp = g_lvl[L-1].po;

    // gp/pp[i] span bits i..0, so the carry into bit i+1 folds in cin.
    assign c[0]   = cin_i;
    assign c[N:1] = gp | (pp & {N{cin_i}});

    assign sum_o  = p0 ^ c[N-1:0];
    assign cout_o = c[N];
    assign p_o    = pp[N-1];
    assign g_o    = gp[N-1];

endmodule

// File: rtl/adder_word_loader.sv
// Streams two N-bit operands in as W-bit words, adds them in one cycle
// and streams the registered sum back out word by word.
module adder_word_loader
    import adder_word_loader_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         in_cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_last,
    output logic         out_carry,
    output logic         out_p,
    output logic         out_g,
    output logic         busy
);

    localparam int K  = N / W;
    localparam int CW = (K > 1) ? $clog2(K) : 1;
    localparam logic [CW-1:0] LAST = CW'(K - 1);

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [N-1:0]  a_q;
    logic [N-1:0]  b_q;
    logic          cin_q;
    logic [N-1:0]  sum_q;
    logic          carry_q;
    logic          p_q;
    logic          g_q;

    logic [N-1:0]  add_sum;
    logic          add_cout;
    logic          add_p;
    logic          add_g;
    logic          cnt_last;

    bit_adder_2n #(
        .N(N)
    ) u_add (
        .a_i    (a_q),
        .b_i    (b_q),
        .cin_i  (cin_q),
        .sum_o  (add_sum),
        .cout_o (add_cout),
        .p_o    (add_p),
        .g_o    (add_g)
    );

    assign cnt_last = (cnt_q == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD_A;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            p_q     <= 1'b0;
            g_q     <= 1'b0;
        end else begin
            unique case (state_q)
                LOAD_A: begin
                    if (in_valid) begin
                        a_q[cnt_q*W +: W] <= in_data;
                        if (cnt_q == '0) cin_q <= in_cin;
                        if (cnt_last) begin
                            cnt_q   <= '0;
                            state_q <= LOAD_B;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                LOAD_B: begin
                    if (in_valid) begin
                        b_q[cnt_q*W +: W] <= in_data;
                        if (cnt_last) begin
                            cnt_q   <= '0;
                            state_q <= ADD;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                ADD: begin
                    sum_q   <= add_sum;
                    carry_q <= add_cout;
                    p_q     <= add_p;
                    g_q     <= add_g;
                    state_q <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        if (cnt_last) begin
                            cnt_q   <= '0;
                            state_q <= LOAD_A;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                default: state_q <= LOAD_A;
            endcase
        end
    end

    // Ready is a state decode, held low while reset is asserted.
    assign in_ready  = rst_n &&
                       ((state_q == LOAD_A) || (state_q == LOAD_B));
    assign out_valid = (state_q == OUT);
    assign out_last  = (state_q == OUT) && cnt_last;
    assign out_data  = sum_q[cnt_q*W +: W];
    assign out_carry = carry_q;
    assign out_p     = p_q;
    assign out_g     = g_q;
    assign busy      = !((state_q == LOAD_A) && (cnt_q == '0));

endmodule

// File: tb/tb_adder_word_loader.sv
// Scoreboard bench for adder_word_loader with N=128, W=32.
// Expected sum words are queued at load time and popped on output.
module tb_adder_word_loader;

    localparam int N = 128;
    localparam int W = 32;
    localparam int K = N / W;

    typedef struct packed {
        logic [W-1:0] d;
        logic         last;
        logic         c;
        logic         p;
        logic         g;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         in_cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_last;
    logic         out_carry;
    logic         out_p;
    logic         out_g;
    logic         busy;

    exp_t sbq[$];
    int   vectors;
    int   miscompares;

    adder_word_loader #(
        .N(N),
        .W(W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_carry (out_carry),
        .out_p     (out_p),
        .out_g     (out_g),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_expect(input logic [N-1:0] a,
                               input logic [N-1:0] b,
                               input logic cin);
        logic [N:0] full;
        logic [N:0] nocin;
        exp_t e;
        nocin = {1'b0, a} + {1'b0, b};
        full  = nocin + {{N{1'b0}}, cin};
        for (int k = 0; k < K; k++) begin
            e.d    = full[k*W +: W];
            e.last = (k == K - 1);
            e.c    = full[N];
            e.p    = &(a ^ b);
            e.g    = nocin[N];
            sbq.push_back(e);
        end
    endtask

    task automatic put(input logic [W-1:0] d, input logic c, input int gap);
        logic ok;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_cin   = c;
        for (int t = 0; t <= 50; t++) begin
            if (t == 50) begin
                vectors++;
                miscompares++;
                $display("FAIL put_timeout: in_ready=%b after 50 cycles, need 1",
                         in_ready);
                break;
            end
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL load_out_valid: got %b during load, need 0",
                         out_valid);
            end
            ok = in_ready;
            @(negedge clk);
            if (ok) break;
        end
    endtask

    task automatic load_op(input logic [N-1:0] a, input logic [N-1:0] b,
                           input logic cin, input int maxgap);
        for (int k = 0; k < K; k++)
            put(a[k*W +: W], (k == 0) ? cin : 1'($urandom_range(0, 1)),
                $urandom_range(0, maxgap));
        for (int k = 0; k < K; k++)
            put(b[k*W +: W], 1'($urandom_range(0, 1)),
                $urandom_range(0, maxgap));
        in_valid = 1'b0;
    endtask

    task automatic get_op(input bit rnd, input int nwords);
        int           words;
        bit           held;
        logic         r;
        logic [W-1:0] hd;
        logic         hl;
        logic         hc;
        exp_t         e;
        words = 0;
        held  = 0;
        hd    = '0;
        hl    = 1'b0;
        hc    = 1'b0;
        for (int t = 0; t <= 400; t++) begin
            if (t == 400) begin
                vectors++;
                miscompares++;
                $display("FAIL get_timeout: got %0d words, need %0d",
                         words, nwords);
                break;
            end
            if (in_ready && out_valid) begin
                vectors++;
                miscompares++;
                $display("FAIL half_duplex: in_ready=1 out_valid=1, need not both");
            end
            if (held) begin
                vectors++;
                if (out_valid !== 1'b1 || out_data !== hd ||
                    out_last !== hl || out_carry !== hc) begin
                    miscompares++;
                    $display("FAIL hold_stable: v=%b d=%h l=%b c=%b, need v=1 d=%h l=%b c=%b",
                             out_valid, out_data, out_last, out_carry, hd, hl, hc);
                end
            end
            r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            out_ready = r;
            if (out_valid === 1'b1 && r) begin
                vectors++;
                if (sbq.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_word: got %h, need no word", out_data);
                end else begin
                    e = sbq.pop_front();
                    if (out_data !== e.d) begin
                        miscompares++;
                        $display("FAIL sum_word%0d: got %h, need %h",
                                 words, out_data, e.d);
                    end
                    vectors++;
                    if ({out_last, out_carry, out_p, out_g} !==
                        {e.last, e.c, e.p, e.g}) begin
                        miscompares++;
                        $display("FAIL flags_word%0d: lcpg got %b%b%b%b, need %b%b%b%b",
                                 words, out_last, out_carry, out_p, out_g,
                                 e.last, e.c, e.p, e.g);
                    end
                end
                words++;
            end
            held = (out_valid === 1'b1) && !r;
            hd   = out_data;
            hl   = out_last;
            hc   = out_carry;
            @(negedge clk);
            if (words == nwords) break;
        end
    endtask

    task automatic check_reset_vals(input string name);
        vectors++;
        if ({in_ready, out_valid, out_last, out_carry, out_p, out_g, busy} !== 7'b0 ||
            out_data !== '0) begin
            miscompares++;
            $display("FAIL %s: rdy/v/l/c/p/g/busy=%b%b%b%b%b%b%b d=%h, need all 0",
                     name, in_ready, out_valid, out_last, out_carry, out_p,
                     out_g, busy, out_data);
        end
    endtask

    task automatic check_release(input string name);
        vectors++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL %s: rdy=%b busy=%b v=%b, need rdy=1 busy=0 v=0",
                     name, in_ready, busy, out_valid);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_cin    = 1'b0;
        out_ready = 1'b1;
        #12;
        check_reset_vals("reset_state");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_release("reset_release");
        @(negedge clk);
    endtask

    task automatic test_simple();
        logic [N-1:0] one;
        one = 1;
        push_expect(one, one, 1'b0);
        load_op(one, one, 1'b0, 0);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL latency_add: out_valid=%b one edge after last B, need 0",
                     out_valid);
        end
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL latency_out: out_valid=%b two edges after last B, need 1",
                     out_valid);
        end
        get_op(0, K);
    endtask

    task automatic test_full_carry();
        push_expect({N{1'b1}}, '0, 1'b1);
        load_op({N{1'b1}}, '0, 1'b1, 1);
        get_op(0, K);
    endtask

    task automatic test_ripple();
        logic [N-1:0] a;
        logic [N-1:0] b;
        a = {{(N-W){1'b0}}, {W{1'b1}}};
        b = 1;
        push_expect(a, b, 1'b0);
        load_op(a, b, 1'b0, 0);
        get_op(1, K);
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         c;
        for (int i = 0; i < 200; i++) begin
            a = {$urandom, $urandom, $urandom, $urandom};
            b = {$urandom, $urandom, $urandom, $urandom};
            if (i % 10 == 3) b = ~a;
            if (i % 10 == 7) b = a;
            c = 1'($urandom_range(0, 1));
            push_expect(a, b, c);
            load_op(a, b, c, 2);
            get_op(1, K);
        end
    endtask

    task automatic test_reset_mid_load();
        logic [N-1:0] a;
        logic [N-1:0] b;
        for (int k = 0; k < 5; k++)
            put($urandom, 1'b1, 0);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_vals("reset_mid_load");
        sbq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_release("release_mid_load");
        @(negedge clk);
        a = {$urandom, $urandom, $urandom, $urandom};
        b = {$urandom, $urandom, $urandom, $urandom};
        push_expect(a, b, 1'b0);
        load_op(a, b, 1'b0, 1);
        get_op(1, K);
    endtask

    task automatic test_reset_mid_output();
        logic [N-1:0] a;
        logic [N-1:0] b;
        a = {$urandom, $urandom, $urandom, $urandom};
        b = {$urandom, $urandom, $urandom, $urandom};
        push_expect(a, b, 1'b1);
        load_op(a, b, 1'b1, 0);
        get_op(0, 2);
        rst_n = 1'b0;
        #1;
        check_reset_vals("reset_mid_output");
        sbq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_release("release_mid_output");
        @(negedge clk);
        a = {$urandom, $urandom, $urandom, $urandom};
        push_expect(a, b, 1'b1);
        load_op(a, b, 1'b1, 0);
        get_op(0, K);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_simple();
        test_full_carry();
        test_ripple();
        test_back_to_back();
        test_reset_mid_load();
        test_reset_mid_output();
        vectors++;
        if (sbq.size() != 0) begin
            miscompares++;
            $display("FAIL leftover: %0d expected words never seen, need 0",
                     sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
